// File: rtl/post_proc_pkg.sv
// post_proc_pkg: shared FSM states, constants and sizing helpers for the post-process frame packer
package post_proc_pkg;
  typedef enum logic [2:0] {IDLE, SOF, FETCH, DATA, CNT, CSUM} pk_state_e;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction
  function automatic int timeout_width(input int timeout);
    return $clog2(timeout);
  endfunction
endpackage

// File: rtl/frame_csum_acc.sv
// frame_csum_acc: 8-bit XOR accumulator; clr_i zeroes it, en_i folds data_i in, csum_o is the running value
module frame_csum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] csum_o
);
  logic [7:0] acc_q;
  always_ff @(posedge clk) acc_q <= (rst || clr_i) ? '0 : en_i ? acc_q ^ data_i : acc_q;
  assign csum_o = acc_q;
endmodule

// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer: drains FWFT FIFO words into SOF/payload/count[/checksum] byte frames on a valid/ready stream.
// Ports: i_fifo_r_data/i_fifo_not_empty/o_fifo_r_stb = FIFO read side; o_tx_data/o_tx_valid/i_tx_ready = byte stream;
// o_busy = not idle; o_frame_cnt = completed frames. Define PACKER_CSUM_EN to append the XOR checksum byte.
module fifo_frame_packer
  import post_proc_pkg::*;
#(
  parameter int         WIDTH       = 16,
  parameter int         FRAME_WORDS = 8,
  parameter int         TIMEOUT     = 1024,
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_fifo_r_data,
  input  logic             i_fifo_not_empty,
  output logic             o_fifo_r_stb,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic [15:0]      o_frame_cnt
);
  localparam int B  = bytes_per_word(WIDTH);
  localparam int TW = timeout_width(TIMEOUT);
  pk_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [7:0]       tx_data_q, tx_data_d, word_cnt_q, word_cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             xfer;
  assign xfer         = tx_valid_q && i_tx_ready;
  assign o_fifo_r_stb = !rst && state_q == FETCH && i_fifo_not_empty;
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_busy       = state_q != IDLE;
  assign o_frame_cnt  = frame_cnt_q;
`ifdef PACKER_CSUM_EN
  logic [7:0] csum;
  frame_csum_acc u_csum (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == IDLE),
    .en_i  (xfer && (state_q == DATA || state_q == CNT)),
    .data_i(tx_data_q),
    .csum_o(csum)
  );
`endif
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    word_cnt_d  = word_cnt_q;
    to_cnt_d    = '0;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: if (i_fifo_not_empty) begin
        state_d    = SOF;
        tx_data_d  = SOF_BYTE;
        tx_valid_d = 1'b1;
      end
      SOF: if (xfer) begin
        state_d    = FETCH;
        tx_valid_d = 1'b0;
      end
      FETCH: if (i_fifo_not_empty) begin
        // a word present on the expiry cycle is taken; the timeout never sees it
        state_d    = DATA;
        shift_d    = i_fifo_r_data << 8;
        tx_data_d  = i_fifo_r_data[WIDTH-1 -: 8];
        tx_valid_d = 1'b1;
        word_cnt_d = word_cnt_q + 8'd1;
        idx_d      = '0;
      end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        // with no payload yet the counter parks at its limit instead of wrapping
        to_cnt_d = to_cnt_q;
        if (word_cnt_q != '0) begin
          state_d    = CNT;
          tx_data_d  = word_cnt_q;
          tx_valid_d = 1'b1;
          to_cnt_d   = '0;
        end
      end else to_cnt_d = to_cnt_q + 1'b1;
      DATA: if (xfer) begin
        if (idx_q == 3'(B - 1)) begin
          state_d    = word_cnt_q == 8'(FRAME_WORDS) ? CNT : FETCH;
          tx_data_d  = word_cnt_q;
          tx_valid_d = word_cnt_q == 8'(FRAME_WORDS);
        end else begin
          tx_data_d = shift_q[WIDTH-1 -: 8];
          shift_d   = shift_q << 8;
          idx_d     = idx_q + 3'd1;
        end
      end
`ifdef PACKER_CSUM_EN
      CNT: if (xfer) begin
        // the accumulator absorbs the count byte on this same edge, so fold it in here
        state_d   = CSUM;
        tx_data_d = csum ^ tx_data_q;
      end
      CSUM: if (xfer) begin
        state_d     = IDLE;
        tx_valid_d  = 1'b0;
        word_cnt_d  = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
`else
      CNT: if (xfer) begin
        state_d     = IDLE;
        tx_valid_d  = 1'b0;
        word_cnt_d  = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      word_cnt_q  <= '0;
      to_cnt_q    <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      word_cnt_q  <= word_cnt_d;
      to_cnt_q    <= to_cnt_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb_fifo_frame_packer: scoreboard bench with a queue-based FIFO and frame-chunking reference model
module tb_fifo_frame_packer;
  localparam int FW = 4;
  localparam int TO = 16;
  logic        clk = 0, rst = 1;
  logic [15:0] fifo_data = '0;
  logic        fifo_ne = 0;
  logic        fifo_stb, tx_valid, busy;
  logic [7:0]  tx_data;
  logic        tx_ready = 1;
  logic [15:0] frame_cnt;
  logic        push_req = 0;
  logic [15:0] push_word = '0;
  logic [15:0] fifo[$];
  logic [7:0]  exp_q[$];
  logic [15:0] stim_q[$];
  int          checks = 0, fails = 0, xfer_cnt = 0, stb_cnt = 0, pops_exp = 0, rdy_mode = 0;
  logic [15:0] model_frames = 0;
  logic        hold_v = 0;
  logic [7:0]  hold_d = 0;

  fifo_frame_packer #(.WIDTH(16), .FRAME_WORDS(FW), .TIMEOUT(TO), .SOF_BYTE(8'hA5)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_fifo_r_data   (fifo_data),
    .i_fifo_not_empty(fifo_ne),
    .o_fifo_r_stb    (fifo_stb),
    .o_tx_data       (tx_data),
    .o_tx_valid      (tx_valid),
    .i_tx_ready      (tx_ready),
    .o_busy          (busy),
    .o_frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // FIFO model: pops on the strobe, takes one pushed word per edge, FWFT head
  always @(posedge clk) begin
    if (rst) fifo.delete();
    else begin
      if (fifo_stb && fifo.size() != 0) void'(fifo.pop_front());
      if (push_req) fifo.push_back(push_word);
    end
    fifo_ne   <= fifo.size() != 0;
    fifo_data <= fifo.size() != 0 ? fifo[0] : '0;
  end

  // ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor
  initial forever begin
    @(negedge clk);
    if (rst) hold_v = 0;
    else begin
      if (hold_v) check("hold", {31'd0, tx_valid} << 8 | tx_data, {23'd0, 1'b1, hold_d});
      if (fifo_stb) begin
        stb_cnt++;
        check("stb_when_empty", fifo_ne, 1);
      end
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_byte: got %0h required none", tx_data);
        end else check("byte", tx_data, exp_q.pop_front());
      end
      hold_v = tx_valid && !tx_ready;
      hold_d = tx_data;
    end
  end

  // reference: words are chunked into frames of FW; a short tail closes by timeout
  task automatic send_burst;
    int n, m;
`ifdef PACKER_CSUM_EN
    logic [7:0] cs;
`endif
    n = stim_q.size();
    for (int i = 0; i < n; i += FW) begin
      m = (n - i < FW) ? n - i : FW;
      exp_q.push_back(8'hA5);
`ifdef PACKER_CSUM_EN
      cs = 8'(m);
`endif
      for (int j = 0; j < m; j++) begin
        exp_q.push_back(stim_q[i+j][15:8]);
        exp_q.push_back(stim_q[i+j][7:0]);
`ifdef PACKER_CSUM_EN
        cs ^= stim_q[i+j][15:8] ^ stim_q[i+j][7:0];
`endif
      end
      exp_q.push_back(8'(m));
`ifdef PACKER_CSUM_EN
      exp_q.push_back(cs);
`endif
      model_frames++;
    end
    pops_exp += n;
    foreach (stim_q[k]) begin
      push_req  = 1;
      push_word = stim_q[k];
      step();
    end
    push_req = 0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      step();
      t++;
    end
    check({name, " drain"}, exp_q.size(), 0);
    check({name, " busy"}, busy, 0);
    check({name, " frame_cnt"}, frame_cnt, model_frames);
    check({name, " pops"}, stb_cnt, pops_exp);
  endtask

  initial begin
    int base, t;
    repeat (3) step();
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst frame_cnt", frame_cnt, 0);
    check("rst busy", busy, 0);
    check("rst r_stb", fifo_stb, 0);
    rst = 0;
    step();
    rdy_mode = 0;
    stim_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    send_burst();
    wait_idle("full");
    stim_q = '{16'h00FF};
    send_burst();
    wait_idle("partial");
    rdy_mode = 1;
    stim_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    send_burst();
    wait_idle("backpressure");
    rdy_mode = 0;
    step();
    base = xfer_cnt;
    exp_q = '{8'hA5, 8'h00, 8'hFF, 8'hAA, 8'hAA, 8'h02};
`ifdef PACKER_CSUM_EN
    exp_q.push_back(8'hFD);
`endif
    model_frames++;
    pops_exp += 2;
    push_req  = 1;
    push_word = 16'h00FF;
    step();
    push_req = 0;
    t = 0;
    while (xfer_cnt < base + 3 && t < 200) begin
      step();
      t++;
    end
    check("expiry sync", xfer_cnt >= base + 3, 1);
    repeat (14) step();
    push_req  = 1;
    push_word = 16'hAAAA;
    step();
    push_req = 0;
    wait_idle("expiry");
    base = xfer_cnt;
    stim_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    send_burst();
    t = 0;
    while (xfer_cnt < base + 3 && t < 200) begin
      step();
      t++;
    end
    check("reset sync", xfer_cnt >= base + 3, 1);
    rst = 1;
    step();
    check("midrst tx_valid", tx_valid, 0);
    check("midrst frame_cnt", frame_cnt, 0);
    check("midrst busy", busy, 0);
    exp_q.delete();
    model_frames = 0;
    stb_cnt      = 0;
    pops_exp     = 0;
    rst = 0;
    step();
    stim_q = '{16'h1234};
    send_burst();
    wait_idle("after_reset");
    rdy_mode = 2;
    for (int b = 0; b < 25; b++) begin
      stim_q.delete();
      repeat ($urandom_range(1, 9)) stim_q.push_back(16'($urandom));
      send_burst();
      wait_idle("random");
      repeat ($urandom_range(0, 3)) step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/fifo_frame_packer.md
Name: fifo_frame_packer

Overview:
Downstream consumer of the post-process word FIFO. Drains WIDTH-bit words through the FIFO's first-word-fall-through read port and packs them into byte frames on an 8-bit valid/ready stream for the UART/host link. Frame layout: SOF, payload bytes (MSB first), count byte, and an optional checksum byte. A frame closes after FRAME_WORDS words, or earlier when the FIFO stays empty for TIMEOUT cycles.

Parameters:
WIDTH, 16, FIFO word width; must be a multiple of 8, and 8..64.
FRAME_WORDS, 8, maximum words per frame; range 1..255.
TIMEOUT, 1024, consecutive empty cycles in FETCH before a partial frame closes; must be ≥2.
SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_fifo_r_data  in  WIDTH  FIFO head word; valid whenever i_fifo_not_empty=1
i_fifo_not_empty  in  1  FIFO holds ≥1 word
o_fifo_r_stb  out  1  pop strobe; combinational, one cycle per word
o_tx_data  out  8  output byte; registered
o_tx_valid  out  1  byte valid; registered
i_tx_ready  in  1  sink accepts byte
o_busy  out  1  FSM not in IDLE
o_frame_cnt  out  16  completed frames; wraps at 0xFFFF→0

Behaviour:
- Reset values: o_tx_valid=0, o_tx_data=0, o_frame_cnt=0, o_busy=0, o_fifo_r_stb=0. Internal state: FSM=IDLE, word_cnt=0, timeout counter=0, checksum=0.
- Transfer rule: a byte transfers on a clk edge with o_tx_valid&&i_tx_ready.
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data is held stable.
  - At most 1 byte per cycle.
- Define B = WIDTH/8.
- States:
  - IDLE: if i_fifo_not_empty, go to SOF and load o_tx_data=SOF_BYTE, o_tx_valid=1. SOF is valid 1 cycle after not_empty is seen.
  - SOF: on transfer, go to FETCH with o_tx_valid=0.
  - FETCH:
    - If i_fifo_not_empty: assert o_fifo_r_stb this cycle and capture i_fifo_r_data into the shift register at the same edge. Then word_cnt++, timeout counter clears, byte index=0, go to DATA with the MSB byte presented.
    - Else: timeout counter++. When it reaches TIMEOUT-1 with word_cnt≥1, go to CNT.
  - DATA: on each transfer, present the next lower byte. After byte B-1 transfers:
    - if word_cnt==FRAME_WORDS, go to CNT;
    - else go to FETCH.
  - CNT: present word_cnt[7:0]. On transfer, go to CSUM; without the optional feature, the frame ends here.
  - CSUM: present the checksum. On transfer the frame ends.
- Checksum: XOR of every payload byte and the count byte; SOF is excluded. Cleared at frame start.
- Frame end: o_frame_cnt++ on the last byte's transfer. FSM returns to IDLE with word_cnt=0 and o_tx_valid=0. A new frame needs at least 1 IDLE cycle.
- FIFO-empty boundary: o_fifo_r_stb is never asserted when i_fifo_not_empty=0, and only asserted in FETCH.
- Simultaneous events: in FETCH, a word arriving in the same cycle the timeout expires wins. The word is popped and the timeout is ignored.
- Latency: a 1-word frame arrives in the FIFO, then the last byte can be valid after 2+B+1+1 cycles (plus TIMEOUT) at full ready.
- Mid-operation reset: an in-flight frame is abandoned and a popped but unsent word is discarded. o_tx_valid=0 on the cycle after rst.

Optional Feature:
PACKER_CSUM_EN
- Defined: the CSUM state exists and a checksum byte closes each frame.
- Undefined: no CSUM state or XOR logic; the frame ends on the CNT transfer, one byte shorter.

Decomposition:
- Package post_proc_pkg holds:
  - FSM state enum (IDLE, SOF, FETCH, DATA, CNT, CSUM);
  - default SOF constant 8'hA5;
  - function bytes_per_word(WIDTH);
  - timeout counter width = $clog2(TIMEOUT).
- One natural sub-module, frame_csum_acc: 8-bit XOR accumulator with clr/en/data inputs. It is instantiated only under PACKER_CSUM_EN.

Test Plan:
1. WIDTH=16, FRAME_WORDS=4, ready=1. Push 0x1234, 0x5678, 0x9ABC, 0xDEF0 → stream A5 12 34 56 78 9A BC DE F0 04 04; o_frame_cnt=1.
2. FRAME_WORDS=4, TIMEOUT=16. Push one word 0x00FF → A5 00 FF; then after 16 empty FETCH cycles, 01 FE.
3. Scenario 1 with i_tx_ready toggling 1,0,0,1 → identical byte sequence; o_tx_data stable on every valid&&!ready cycle; no duplicate pops (exactly 4 r_stb pulses).
4. rst asserted after 3 bytes of scenario 1 → o_tx_valid=0 next cycle, o_frame_cnt=0. Push 0x1234 again → new frame begins with A5.
5. PACKER_CSUM_EN undefined, scenario 1 → 10 bytes ending in 04; no 11th byte.
6. TIMEOUT=16, push 0x00FF, then push 0xAAAA exactly on expiry cycle → word popped, frame continues: A5 00 FF AA AA ...; count later = 02.
